// File: rtl/i2c_frame_scheduler.sv
// i2c_frame_scheduler: round-robin arbiter that turns one granted request into
// a complete I2C write frame (START+device address, register address,
// 0..MAX_BYTES payload bytes, STOP) driven through a byte-level I2C master.
// A per-phase watchdog drops a frame whose master handshake stalls.
module i2c_frame_scheduler #(
  parameter int          NUM_REQ   = 2,
  parameter int          MAX_BYTES = 5,
  parameter logic [7:0]  DEV_ADDR  = 8'hAA,
  parameter int          TIMEOUT   = 4096
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*8-1:0]           req_reg_addr,
  input  logic [NUM_REQ*3-1:0]           req_len,
  input  logic [NUM_REQ*MAX_BYTES*8-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           frame_err,
  output logic                           start,
  output logic                           stop,
  output logic                           i2c_en,
  output logic [7:0]                     tx_data,
  input  logic                           ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, DONE, ERR} state_t;

  state_t             state_reg, state_next;
  logic [3:0]         elem_reg, elem_next;
  logic [WD_W-1:0]    wd_reg, wd_next;
  logic [IDX_W-1:0]   last_grant_reg, last_grant_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [NUM_REQ-1:0] ack_reg, ack_next;
  logic [7:0]         reg_addr_reg, reg_addr_next;
  logic [2:0]         len_reg, len_next;
  logic [7:0]         data_reg  [MAX_BYTES];
  logic [7:0]         data_next [MAX_BYTES];

  // Per-requester views of the flattened request buses
  logic [7:0] reg_arr  [NUM_REQ];
  logic [2:0] len_arr  [NUM_REQ];
  logic [7:0] data_arr [NUM_REQ][MAX_BYTES];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign reg_arr[gi] = req_reg_addr[gi*8 +: 8];
    assign len_arr[gi] = req_len[gi*3 +: 3];
    for (genvar gk = 0; gk < MAX_BYTES; gk++) begin : g_byte
      assign data_arr[gi][gk] = req_data[(gi*MAX_BYTES+gk)*8 +: 8];
    end
  end

  // Round-robin search starting one past the previous owner
  logic             found;
  logic [IDX_W-1:0] win_idx;
  int               cand;
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant_reg) + k) % NUM_REQ;
      if (!found && req_valid[IDX_W'(cand)]) begin
        found   = 1'b1;
        win_idx = IDX_W'(cand);
      end
    end
  end

  // Oversized lengths are clamped so the frame never reads past the payload
  logic [2:0] win_len, clamped_len;
  assign win_len     = len_arr[win_idx];
  assign clamped_len = (win_len > 3'(MAX_BYTES)) ? 3'(MAX_BYTES) : win_len;

  // Element index of the STOP command for the latched frame
  logic [3:0] stop_elem;
  assign stop_elem = {1'b0, len_reg} + 4'd2;

  // Select the payload byte for elements 2..L+1
  logic [7:0] payload_byte;
  always_comb begin
    payload_byte = 8'h00;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (elem_reg == 4'(k + 2)) payload_byte = data_reg[k];
    end
  end

  // Command outputs decoded only from state and element index
  always_comb begin
    i2c_en  = (state_reg == ISSUE);
    start   = 1'b0;
    stop    = 1'b0;
    tx_data = 8'h00;
    if (state_reg == ISSUE) begin
      if (elem_reg == 4'd0) begin
        start   = 1'b1;
        tx_data = DEV_ADDR;
      end else if (elem_reg == 4'd1) begin
        tx_data = reg_addr_reg;
      end else if (elem_reg == stop_elem) begin
        stop    = 1'b1;
        tx_data = 8'h00;
      end else begin
        tx_data = payload_byte;
      end
    end
  end

  assign req_ack    = ack_reg;
  assign grant      = grant_reg;
  assign busy       = (state_reg != IDLE);
  assign frame_done = (state_reg == DONE);
  assign frame_err  = (state_reg == ERR);

  // Next-state, arbitration capture and watchdog logic
  always_comb begin
    state_next      = state_reg;
    elem_next       = elem_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    ack_next        = '0;
    reg_addr_next   = reg_addr_reg;
    len_next        = len_reg;
    for (int k = 0; k < MAX_BYTES; k++) data_next[k] = data_reg[k];

    case (state_reg)
      IDLE: begin
        if (ready && found) begin
          state_next      = ISSUE;
          grant_next      = NUM_REQ'(1) << win_idx;
          ack_next        = NUM_REQ'(1) << win_idx;
          last_grant_next = win_idx;
          reg_addr_next   = reg_arr[win_idx];
          len_next        = clamped_len;
          elem_next       = 4'd0;
          for (int k = 0; k < MAX_BYTES; k++) data_next[k] = data_arr[win_idx][k];
        end
      end
      ISSUE: begin
        // Watchdog wins over a same-cycle acceptance: the phase already overran
        if (wd_reg == WD_W'(TIMEOUT - 1)) state_next = ERR;
        else if (!ready)                  state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (wd_reg == WD_W'(TIMEOUT - 1)) begin
          state_next = ERR;
        end else if (ready) begin
          if (elem_reg == stop_elem) begin
            state_next = DONE;
          end else begin
            elem_next  = elem_reg + 4'd1;
            state_next = ISSUE;
          end
        end
      end
      DONE: begin
        grant_next = '0;
        state_next = IDLE;
      end
      ERR: begin
        grant_next = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Watchdog restarts on every state change and only runs in handshake phases
    if (state_next != state_reg)
      wd_next = '0;
    else if (state_reg == ISSUE || state_reg == WAIT_DONE)
      wd_next = wd_reg + WD_W'(1);
    else
      wd_next = '0;
  end

  // State and latch registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      elem_reg       <= '0;
      wd_reg         <= '0;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
      grant_reg      <= '0;
      ack_reg        <= '0;
      reg_addr_reg   <= '0;
      len_reg        <= '0;
      for (int k = 0; k < MAX_BYTES; k++) data_reg[k] <= '0;
    end else begin
      state_reg      <= state_next;
      elem_reg       <= elem_next;
      wd_reg         <= wd_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
      ack_reg        <= ack_next;
      reg_addr_reg   <= reg_addr_next;
      len_reg        <= len_next;
      for (int k = 0; k < MAX_BYTES; k++) data_reg[k] <= data_next[k];
    end
  end

endmodule

// File: tb/tb_i2c_frame_scheduler.sv
// Testbench for i2c_frame_scheduler: a byte-master responder pops expected
// commands from a scoreboard queue; frame-level vectors come from a table.
module tb_i2c_frame_scheduler;

  localparam int         NUM_REQ   = 2;
  localparam int         MAX_BYTES = 5;
  localparam int         TIMEOUT   = 4096;
  localparam logic [7:0] DEV_ADDR  = 8'hAA;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_reg_addr = '0;
  logic [5:0]  req_len = '0;
  logic [79:0] req_data = '0;
  logic [1:0]  req_ack, grant;
  logic        busy, frame_done, frame_err, start, stop, i2c_en;
  logic [7:0]  tx_data;
  logic        ready;

  i2c_frame_scheduler #(
    .NUM_REQ(NUM_REQ), .MAX_BYTES(MAX_BYTES), .DEV_ADDR(DEV_ADDR), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_reg_addr(req_reg_addr),
    .req_len(req_len), .req_data(req_data), .req_ack(req_ack), .grant(grant),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err), .start(start),
    .stop(stop), .i2c_en(i2c_en), .tx_data(tx_data), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic s; logic p; logic [7:0] b; } cmd_t;
  typedef struct { int r; logic [7:0] ra; logic [2:0] ln; logic [39:0] d; } vec_t;

  cmd_t       exp_q[$];
  vec_t       vecs[5];
  int         checks = 0, errors = 0;
  int         cyc = 0, cmd_idx = 0, lo_cnt = 0, stall_cyc = 0, err_cyc = 0;
  bit         stuck_mode = 0, stalled = 0, force_low = 0;
  logic [1:0] exp_grant = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {14'b0, req_ack, grant, busy, frame_done, frame_err, start, stop, i2c_en, tx_data};
  endfunction

  // Byte-master responder: accepts a command, holds ready low 3 cycles
  initial begin
    cmd_t c;
    ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (reset) begin
        ready = 1'b1; lo_cnt = 0; cmd_idx = 0; stalled = 0;
      end else begin
        if (frame_err && err_cyc == 0) err_cyc = cyc;
        if (frame_done || frame_err) cmd_idx = 0;
        if (force_low) begin
          ready = 1'b0; lo_cnt = 0;
        end else if (ready && i2c_en && !stalled) begin
          $display("cmd %0d: start=%0d stop=%0d data=%02h grant=%b", cmd_idx, start, stop, tx_data, grant);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cmd: got start=%0d stop=%0d data=%02h expected none", start, stop, tx_data);
          end else begin
            c = exp_q.pop_front();
            chk("cmd", {22'b0, start, stop, tx_data}, {22'b0, c});
            chk("cmd_grant", {30'b0, grant}, {30'b0, exp_grant});
          end
          cmd_idx++;
          if (stuck_mode && cmd_idx == 2) begin
            stalled = 1; stall_cyc = cyc;
          end else begin
            ready = 1'b0; lo_cnt = 3;
          end
        end else if (!ready) begin
          if (lo_cnt <= 1) ready = 1'b1;
          else lo_cnt--;
        end
      end
    end
  end

  task automatic push_frame(input logic [7:0] ra, input logic [2:0] ln, input logic [39:0] d);
    int n;
    n = (int'(ln) > MAX_BYTES) ? MAX_BYTES : int'(ln);
    exp_q.push_back('{1'b1, 1'b0, DEV_ADDR});
    exp_q.push_back('{1'b0, 1'b0, ra});
    for (int k = 0; k < n; k++) exp_q.push_back('{1'b0, 1'b0, d[k*8 +: 8]});
    exp_q.push_back('{1'b0, 1'b1, 8'h00});
  endtask

  task automatic drive_req(input int r, input logic [7:0] ra, input logic [2:0] ln, input logic [39:0] d);
    req_reg_addr[r*8 +: 8] = ra;
    req_len[r*3 +: 3]      = ln;
    req_data[r*40 +: 40]   = d;
    req_valid[r]           = 1'b1;
  endtask

  task automatic wait_ack(output logic [1:0] a, output int lat);
    a = '0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (req_ack != 0) begin a = req_ack; lat = i; break; end
    end
  endtask

  task automatic wait_end(input int limit, output logic d, output logic e);
    d = 0; e = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (frame_done || frame_err) begin d = frame_done; e = frame_err; break; end
    end
  endtask

  task automatic run_frame(input vec_t v);
    logic [1:0] a; int lat; logic dn, er;
    @(negedge clk);
    exp_grant = 2'(1 << v.r);
    push_frame(v.ra, v.ln, v.d);
    drive_req(v.r, v.ra, v.ln, v.d);
    wait_ack(a, lat);
    chk("ack", {30'b0, a}, 32'(1 << v.r));
    chk("ack_latency", lat, 1);
    chk("grant_busy_en", {28'b0, grant, busy, i2c_en}, {28'b0, exp_grant, 2'b11});
    req_valid[v.r] = 1'b0;
    req_data[v.r*40 +: 40]  = ~v.d;
    req_reg_addr[v.r*8 +: 8] = ~v.ra;
    wait_end(400, dn, er);
    chk("frame_done", {30'b0, dn, er}, 32'b10);
    chk("queue_empty", exp_q.size(), 0);
    $display("frame req%0d reg=%02h len=%0d done=%0d err=%0d", v.r, v.ra, v.ln, dn, er);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] a; int lat; logic dn, er; int ackcnt; int cnt;

    vecs[0] = '{0, 8'h00, 3'd5, 40'h5544332211};
    vecs[1] = '{1, 8'h3C, 3'd0, 40'hFFEEDDCCBB};
    vecs[2] = '{0, 8'h7E, 3'd7, 40'h0504030201};
    vecs[3] = '{1, 8'h12, 3'd1, 40'h0000000099};
    vecs[4] = '{1, 8'h5A, 3'd3, 40'h00C3B2A1F0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), 0);
    reset = 1'b0;

    // Table-driven frames: single frame, zero length, clamp, misc
    for (int i = 0; i < 5; i++) run_frame(vecs[i]);

    // Round robin with both requests held
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; exp_q.delete();
    for (int i = 0; i < 4; i++) push_frame((i % 2 == 0) ? 8'h10 : 8'h20, 3'd1, (i % 2 == 0) ? 40'h01 : 40'h02);
    exp_grant = 2'b01;
    drive_req(0, 8'h10, 3'd1, 40'h01);
    drive_req(1, 8'h20, 3'd1, 40'h02);
    for (int i = 0; i < 4; i++) begin
      exp_grant = (i % 2 == 0) ? 2'b01 : 2'b10;
      wait_ack(a, lat);
      chk("rr_ack", {30'b0, a}, {30'b0, exp_grant});
      if (i == 3) req_valid = '0;
      @(negedge clk);
      chk("ack_pulse", {30'b0, req_ack}, 0);
      wait_end(400, dn, er);
      chk("rr_done", {30'b0, dn, er}, 32'b10);
      $display("rr frame %0d ack=%b", i, a);
    end
    chk("rr_queue_empty", exp_q.size(), 0);

    // ready low in IDLE holds off the acknowledge
    @(negedge clk); force_low = 1;
    @(negedge clk); @(negedge clk);
    exp_grant = 2'b01;
    push_frame(8'h44, 3'd2, 40'h0000008877);
    drive_req(0, 8'h44, 3'd2, 40'h0000008877);
    ackcnt = 0;
    repeat (5) begin @(negedge clk); if (req_ack != 0) ackcnt++; end
    chk("no_ack_ready_low", ackcnt, 0);
    force_low = 0;
    @(negedge clk);
    chk("ack_wait_ready", {30'b0, req_ack}, 0);
    @(negedge clk);
    chk("ack_after_ready", {30'b0, req_ack}, 32'b01);
    req_valid[0] = 1'b0;
    wait_end(400, dn, er);
    chk("ready_low_done", {30'b0, dn, er}, 32'b10);
    $display("ready-low frame done=%0d", dn);

    // Watchdog: master stalls after the register-address command
    @(negedge clk);
    stuck_mode = 1; err_cyc = 0; exp_grant = 2'b10;
    exp_q.push_back('{1'b1, 1'b0, DEV_ADDR});
    exp_q.push_back('{1'b0, 1'b0, 8'h66});
    drive_req(1, 8'h66, 3'd2, 40'h0000002211);
    wait_ack(a, lat);
    chk("wd_ack", {30'b0, a}, 32'b10);
    req_valid[1] = 1'b0;
    wait_end(TIMEOUT + 100, dn, er);
    chk("wd_err", {30'b0, dn, er}, 32'b01);
    chk("wd_latency", err_cyc - stall_cyc, TIMEOUT);
    chk("wd_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("after_err", {30'b0, grant, busy}, 0);
    $display("watchdog frame err=%0d after %0d cycles", er, err_cyc - stall_cyc);
    stuck_mode = 0; stalled = 0;
    run_frame(vecs[0]);

    // Reset during the third data byte
    @(negedge clk);
    exp_grant = 2'b01;
    push_frame(8'h00, 3'd5, 40'h5544332211);
    drive_req(0, 8'h00, 3'd5, 40'h5544332211);
    wait_ack(a, lat);
    req_valid[0] = 1'b0;
    cnt = 0;
    while (cmd_idx < 5 && cnt < 200) begin @(negedge clk); cnt++; end
    chk("reached_byte3", cmd_idx, 5);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_outputs", out_vec(), 0);
    reset = 1'b0; exp_q.delete();
    @(negedge clk);
    exp_grant = 2'b01;
    push_frame(8'h21, 3'd1, 40'h00000000AB);
    drive_req(1, 8'h31, 3'd1, 40'h00000000CD);
    drive_req(0, 8'h21, 3'd1, 40'h00000000AB);
    wait_ack(a, lat);
    chk("post_reset_first", {30'b0, a}, 32'b01);
    req_valid = '0;
    wait_end(400, dn, er);
    chk("post_reset_done", {30'b0, dn, er}, 32'b10);
    chk("post_reset_queue", exp_q.size(), 0);
    $display("post-reset frame ack=%b done=%0d", a, dn);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_frame_scheduler.md
# i2c_frame_scheduler

Shares one byte-level I2C master between several frame requesters, such as ball-state updates and lose notifications, using round-robin arbitration. Each granted request becomes one full I2C write frame: START + device address, register address, 0..MAX_BYTES payload bytes, STOP. A watchdog aborts any frame whose master handshake stalls. The block sits between the game-logic producers and the byte-level I2C master.

## Interface
- NUM_REQ, 2: number of requesters (2..4).
- MAX_BYTES, 5: maximum payload bytes per frame (1..7).
- DEV_ADDR, 8'hAA: device-address byte sent with START.
- TIMEOUT, 4096: watchdog limit, in cycles, per handshake phase.
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester frame request (level).
- req_reg_addr  in  NUM_REQ*8  slave register address; requester i uses [i*8 +: 8].
- req_len  in  NUM_REQ*3  payload length; requester i uses [i*3 +: 3].
- req_data  in  NUM_REQ*MAX_BYTES*8  payload; byte k of requester i is at [(i*MAX_BYTES+k)*8 +: 8]; byte 0 is sent first.
- req_ack  out  NUM_REQ  one-cycle pulse: request captured.
- grant  out  NUM_REQ  one-hot owner of the current frame.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse: frame completed with STOP.
- frame_err  out  1  one-cycle pulse: frame aborted by watchdog.
- start  out  1  command flag: START + tx_data.
- stop  out  1  command flag: STOP.
- i2c_en  out  1  command valid to the byte master.
- tx_data  out  8  command byte.
- ready  in  1  byte master idle/accept indicator.

## Operation
- States: IDLE, ISSUE, WAIT_DONE, DONE, ERR.
- IDLE: if ready==1 and any req_valid, select a winner by round-robin.
  - The search starts at last_grant+1 and wraps modulo NUM_REQ.
  - Register grant and last_grant for the winner; pulse req_ack for the winner.
  - Latch reg_addr, data and len; a len above MAX_BYTES is clamped to MAX_BYTES.
  - Clear the element index, then go to ISSUE.
  - If ready==0, stay in IDLE.
- Element sequence (index e; L = latched len):
  - e=0: start=1, tx_data=DEV_ADDR.
  - e=1: tx_data=reg_addr.
  - e=2..L+1: tx_data=data[e-2].
  - e=L+2: stop=1, tx_data=8'h00.
- ISSUE:
  - i2c_en=1 and the element's flags/byte are held stable.
  - When ready==0 (command accepted), go to WAIT_DONE.
- WAIT_DONE:
  - i2c_en=0.
  - When ready==1: if e==L+2, go to DONE; otherwise e+=1 and go to ISSUE.
- DONE: pulse frame_done, clear grant, go to IDLE.
- Watchdog:
  - The counter clears on every state change.
  - If the counter reaches TIMEOUT-1 in ISSUE or WAIT_DONE, go to ERR.
  - ERR: pulse frame_err, clear grant, go to IDLE. No STOP is issued and the frame is dropped.
- Payload handling:
  - The requester may drop or change req_valid and its payload after req_ack.
  - A request still asserted after its frame completes is served again, subject to round-robin.
- L=0 is legal: the frame is address + register + STOP (3 commands).

## Timing
- Reset values:
  - state IDLE, all outputs 0.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - e, watchdog and latches are 0.
- Reset mid-frame: the next cycle is IDLE with all outputs 0, and no STOP is emitted.
- Latency:
  - req_valid sampled at edge T (IDLE, ready=1).
  - req_ack, grant, busy and i2c_en are high from cycle T+1.
- busy = (state != IDLE). busy is high in DONE and ERR and low the cycle after.
- start, stop, i2c_en and tx_data are registered or decoded from state and e only; they do not depend combinationally on ready.
- Minimum frame duration: each command takes at least 2 cycles (ISSUE + WAIT_DONE), plus 1 cycle for DONE.
- Simultaneous requests: exactly one req_ack per arbitration. The others wait without loss; they are level-held by their requesters.
- A request arriving while busy is not acknowledged until the scheduler returns to IDLE.

## Test plan
- Single frame:
  - Stimulus: req0, reg 8'h00, len 5, data 11,22,33,44,55; the master model holds ready low for 3 cycles per command.
  - Required: 8 commands in order AA(start), 00, 11, 22, 33, 44, 55, 00(stop); one frame_done; grant==01 throughout.
- Round robin:
  - Stimulus: req0 and req1 held continuously.
  - Required: req_ack alternates 01, 10, 01, …; the first grant goes to req0 after reset.
- Zero length and clamp:
  - Stimulus: req1 with len 0.
  - Required: commands AA(start), reg, stop.
  - Stimulus: len 7 with MAX_BYTES=5.
  - Required: exactly 5 data bytes.
- Watchdog:
  - Stimulus: the master never drops ready after the reg-address command is issued.
  - Required: frame_err pulses TIMEOUT cycles after ISSUE entry; no stop; the next request is then served normally.
- Reset mid-frame:
  - Stimulus: assert reset during the third data byte.
  - Required: all outputs 0 next cycle; after release, req0 is granted first again.
- ready low in IDLE:
  - Stimulus: req_valid asserted while ready=0.
  - Required: no req_ack until ready=1; the ack then follows one cycle later.
